// File: rtl/key_schedule.sv
// One registered round of the DES key schedule: rotates both 28-bit halves of the
// post-PC1 key state and derives the 48-bit round subkey through PC2.
module key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] x,
  input  logic [3:0]  i,
  output logic [55:0] r,
  output logic [47:0] k
);

  // PC2 entries in DES numbering: subkey bit m+1 takes key-state bit PC2[m].
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [27:0] rotl28(input logic [27:0] h, input logic two);
    logic [27:0] res;
    if (two) begin
      res = {h[25:0], h[27:26]};
    end else begin
      res = {h[26:0], h[27]};
    end
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] st);
    logic [47:0] res;
    res = 48'h0;
    for (int m = 0; m < 48; m++) begin
      res[6'(47 - m)] = st[6'(56 - PC2[m])];
    end
    return res;
  endfunction

  logic        two_s;
  logic [55:0] r_next_s;
  logic [47:0] k_next_s;

  // Rounds 1, 2, 9 and 16 shift by one position, all others by two.
  always_comb begin
    two_s = 1'b1;
    case (i)
      4'd0, 4'd1, 4'd8, 4'd15: two_s = 1'b0;
      default:                 two_s = 1'b1;
    endcase
  end

  // Next key state and its subkey; C and D rotate independently.
  always_comb begin
    r_next_s = {rotl28(x[55:28], two_s), rotl28(x[27:0], two_s)};
    k_next_s = pc2(r_next_s);
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= 56'h0;
      k <= 48'h0;
    end else begin
      r <= r_next_s;
      k <= k_next_s;
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: reset behaviour, known DES vectors,
// full 16-round chain and randomized back-to-back rounds against a DES-bit model.
module tb_key_schedule;

  logic        clk;
  logic        rst_n;
  logic [55:0] x;
  logic [3:0]  i;
  logic [55:0] r;
  logic [47:0] k;

  int vectors;
  int miscompares;

  key_schedule dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .i    (i),
    .r    (r),
    .k    (k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pc2_tab [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Standard DES subkeys K1..K16 for key 133457799BBCDFF1.
  logic [47:0] des_k [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  // Reference model working on DES-numbered bit arrays.
  function automatic void model(input logic [55:0] xin, input logic [3:0] idx,
                                output logic [55:0] rn, output logic [47:0] kn);
    bit b [1:56];
    bit t;
    int s;
    s = (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 1 : 2;
    for (int n = 1; n <= 56; n++) b[n] = xin[56 - n];
    for (int step = 0; step < s; step++) begin
      t = b[1];
      for (int n = 1; n < 28; n++) b[n] = b[n + 1];
      b[28] = t;
      t = b[29];
      for (int n = 29; n < 56; n++) b[n] = b[n + 1];
      b[56] = t;
    end
    for (int n = 1; n <= 56; n++) rn[56 - n] = b[n];
    for (int m = 1; m <= 48; m++) kn[48 - m] = b[pc2_tab[m]];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      x = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
      i = 4'($urandom_range(15));
      @(posedge clk); #1;
      vectors++;
      if (r !== 56'h0 || k !== 48'h0) begin
        miscompares++;
        $display("FAIL reset_hold: r=%h k=%h, required 0/0", r, k);
      end
    end
    rst_n = 1'b1;
    x = 56'hF0CCAAF556678F;
    i = 4'd0;
    @(posedge clk); #1;
    vectors++;
    if (r !== 56'hE19955FAACCF1E) begin
      miscompares++;
      $display("FAIL reset_release: r=%h, required E19955FAACCF1E", r);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (r !== 56'h0 || k !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_async: r=%h k=%h, required 0/0 before edge", r, k);
    end
    x = 56'hC332ABF5599E3D;
    i = 4'd2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (r !== 56'h0CCAAFF56678F5 || k !== 48'h55FC8A42CF99) begin
      miscompares++;
      $display("FAIL reset_no_history: r=%h k=%h, required 0CCAAFF56678F5/55FC8A42CF99", r, k);
    end
  endtask

  task automatic test_known_vectors();
    logic [55:0] vx [0:3] = '{56'hF0CCAAF556678F, 56'hE19955FAACCF1E,
                              56'hC332ABF5599E3D, 56'hF866557AAB33C7};
    logic [3:0]  vi [0:3] = '{4'd0, 4'd1, 4'd2, 4'd15};
    logic [55:0] vr [0:3] = '{56'hE19955FAACCF1E, 56'hC332ABF5599E3D,
                              56'h0CCAAFF56678F5, 56'hF0CCAAF556678F};
    logic [47:0] vk [0:3] = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5,
                              48'h55FC8A42CF99, 48'hCB3D8B0E17F5};
    for (int n = 0; n < 4; n++) begin
      x = vx[n];
      i = vi[n];
      @(posedge clk); #1;
      vectors++;
      if (r !== vr[n] || k !== vk[n]) begin
        miscompares++;
        $display("FAIL known_vec%0d: r=%h k=%h, required %h/%h", n, r, k, vr[n], vk[n]);
      end
    end
  endtask

  task automatic test_chain();
    x = 56'hF0CCAAF556678F;
    for (int rd = 0; rd < 16; rd++) begin
      i = 4'(rd);
      @(posedge clk); #1;
      vectors++;
      if (k !== des_k[rd]) begin
        miscompares++;
        $display("FAIL chain_k%0d: k=%h, required %h", rd + 1, k, des_k[rd]);
      end
      x = r;
    end
    vectors++;
    if (r !== 56'hF0CCAAF556678F) begin
      miscompares++;
      $display("FAIL chain_wrap: r=%h, required F0CCAAF556678F", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] er;
    logic [47:0] ek;
    for (int n = 0; n < 200; n++) begin
      x = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
      i = 4'($urandom_range(15));
      model(x, i, er, ek);
      @(posedge clk); #1;
      vectors++;
      if (r !== er || k !== ek) begin
        miscompares++;
        $display("FAIL random%0d: x=%h i=%0d r=%h k=%h, required %h/%h",
                 n, x, i, r, k, er, ek);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    x           = 56'h0;
    i           = 4'd0;
    #2;
    test_reset();
    test_known_vectors();
    test_chain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
